data_ram_ctrl: RTL and testbench
================================

Name: data_ram_ctrl

Overview:
Parametrised single-port data memory for the processor datapath, the successor to the fixed 32x301 data RAM.
- Adds configurable width and depth, byte-lane write enables, and a valid/ready request handshake.
- Registered read data carries a valid strobe; out-of-range accesses are detected and reported.
- After reset, a hardware sequencer clears the array before any request is accepted.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 10, address bus width.
DEPTH, 301, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_write  input  1  1 = write, 0 = read; sampled on accept.
address  input  ADDR_WIDTH  word address; sampled on accept.
write_data  input  DATA_WIDTH  write data; sampled on accept.
byte_enable  input  DATA_WIDTH/8  per-byte write mask; bit i controls bits [8i+7:8i].
read_data  output  DATA_WIDTH  registered read result.
read_valid  output  1  one-cycle pulse; read_data is valid.
addr_error  output  1  one-cycle pulse; the previously accepted request was out of range.
init_done  output  1  high once the clear sequence has completed.

Behaviour:
- Reset (asynchronous): state=INIT, clear counter=0, req_ready=0, read_valid=0, read_data=0, addr_error=0, init_done=0. Reset asserted mid-operation aborts any access and restarts INIT. No memory contents are guaranteed until INIT completes again.
- FSM has two states, INIT and RUN.
- INIT state:
  - Each cycle, write all-zero to word[counter], then increment the counter.
  - When counter==DEPTH-1 is written, go to RUN on the next edge.
  - INIT lasts exactly DEPTH cycles after reset deassertion.
  - req_ready=0 throughout; requests are ignored, not queued.
- RUN state:
  - req_ready=1 combinationally; init_done=1 (registered, set on entry to RUN).
  - Accept = req_valid & req_ready.
- Write accept:
  - If address < DEPTH, each byte lane with byte_enable=1 takes write_data's byte at the same edge; other lanes keep their value.
  - byte_enable=0 is a legal no-op.
  - No read_valid pulse is produced.
- Read accept:
  - read_data = word[address] on the next edge (latency 1); read_valid=1 for that one cycle.
  - read_data holds its value until the next read completes; it is not cleared when read_valid drops.
- Out-of-range (address >= DEPTH):
  - The write is dropped; a read returns all-zero with read_valid=1.
  - addr_error pulses 1 cycle after the accept, for both reads and writes.
- Back-to-back: one request is accepted per cycle, with no bubbles. A read accepted the cycle after a write to the same address returns the newly written bytes.
- Single port: at most one access per cycle; no simultaneous read/write case exists.
- No wrap-around: the address is never truncated modulo DEPTH.

Decomposition:
- Shared package (data_ram_pkg): FSM state typedef (INIT, RUN), BYTE_LANES = DATA_WIDTH/8 constant function, and a parameter-legality check (DATA_WIDTH%8==0, DEPTH bounds) asserted at elaboration.
- Sub-module data_ram_array holds the storage:
  - DEPTH x DATA_WIDTH array with a per-byte write mask and a registered read port.
  - No reset on the array.
  - The controller (FSM, clear counter, range check, strobes) stays in data_ram_ctrl.

Test Plan:
1. Reset high 3 cycles, then low -> req_ready=0 and init_done=0 for exactly 301 cycles, then both 1. Read addresses 0, 150 and 300 -> read_data=0x00000000 with read_valid pulsed.
2. After init, write addr 5 data 0xDEADBEEF be=4'b1111; next cycle write addr 5 data 0x11223344 be=4'b0101; then read addr 5 -> read_data=0xDE22BE44 one cycle after accept.
3. Write addr 7 = 0xA5A5A5A5 then immediately read addr 7 on the next cycle -> read_data=0xA5A5A5A5; read_valid high for exactly 1 cycle.
4. Write addr 301 data 0xFFFFFFFF, then read addr 301 and addr 1023 -> addr_error pulses after each accept; reads return 0; a read of addr 300 still returns 0.
5. Drive req_valid=1 (read addr 0) during INIT -> no read_valid and no addr_error until RUN. Assert reset at INIT cycle 100 -> init restarts and completes 301 cycles after the second deassertion.
6. Reset mid-RUN while a read is in flight -> read_valid, read_data and init_done drop to 0 immediately (asynchronously), without waiting for a clock edge.

Source files
------------

// File: rtl/data_ram_pkg.sv
// ============================================================================
// Module      : data_ram_pkg
// Description : Shared types and helper functions for the parametrised data RAM
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_ram_pkg;

    // Controller sequencing: clear the array first, then serve requests.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ram_state_t;

    // Number of byte lanes in a word.
    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

    // Index width needed to address DEPTH words; never below one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Legal configurations: whole bytes per word, 1 <= DEPTH <= 2**ADDR_WIDTH.
    function automatic bit params_ok(input int data_width, input int addr_width,
                                     input int depth);
        return (data_width > 0) && (data_width % 8 == 0) &&
               (addr_width >= 1) && (addr_width < 31) &&
               (depth >= 1) && (depth <= (1 << addr_width));
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram_array.sv
// ============================================================================
// Module      : data_ram_array
// Description : DEPTH x DATA_WIDTH storage with byte write mask and a
//               registered read port. The storage itself has no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 301,
    parameter int IDX_W      = 9
) (
    input  logic                    clock,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [IDX_W-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_mask,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int LANES = byte_lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Read register only updates on a read, so it keeps the last word fetched.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[addr];
        end
    end

    // Byte-masked write and read register update.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i]) begin
                    mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/data_ram_ctrl.sv
// ============================================================================
// Module      : data_ram_ctrl
// Description : Single-port data memory controller: post-reset clear
//               sequencer, valid/ready request handshake, range checking,
//               registered read data with valid and error strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_ctrl
    import data_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 301
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] byte_enable,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    addr_error,
    output logic                    init_done
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    if (!params_ok(DATA_WIDTH, ADDR_WIDTH, DEPTH)) begin : g_param_check
        $error("data_ram_ctrl: illegal DATA_WIDTH/ADDR_WIDTH/DEPTH combination");
    end

    ram_state_t              state_q, state_d;
    logic [IDX_W-1:0]        clear_cnt_q, clear_cnt_d;
    logic                    init_done_q, init_done_d;
    logic                    read_valid_q, read_valid_d;
    logic                    rd_oor_q, rd_oor_d;
    logic                    addr_error_q, addr_error_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;

    logic                    in_range;
    logic                    arr_wr_en;
    logic                    arr_rd_en;
    logic [IDX_W-1:0]        arr_addr;
    logic [DATA_WIDTH-1:0]   arr_wdata;
    logic [DATA_WIDTH/8-1:0] arr_mask;
    logic [DATA_WIDTH-1:0]   arr_rdata;

    // Full-width compare so no address is ever folded back into range.
    assign in_range = ({1'b0, address} < DEPTH_EXT);

    // Next-state, clear sequencing, request decode and array control.
    always_comb begin
        state_d      = state_q;
        clear_cnt_d  = clear_cnt_q;
        init_done_d  = init_done_q;
        read_valid_d = 1'b0;
        rd_oor_d     = 1'b0;
        addr_error_d = 1'b0;
        req_ready    = 1'b0;
        arr_wr_en    = 1'b0;
        arr_rd_en    = 1'b0;
        arr_addr     = address[IDX_W-1:0];
        arr_wdata    = write_data;
        arr_mask     = byte_enable;
        case (state_q)
            ST_INIT: begin
                arr_wr_en = 1'b1;
                arr_addr  = clear_cnt_q;
                arr_wdata = '0;
                arr_mask  = '1;
                if (clear_cnt_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    clear_cnt_d = clear_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_error_d = ~in_range;
                    if (req_write) begin
                        arr_wr_en = in_range;
                    end else begin
                        arr_rd_en    = in_range;
                        read_valid_d = 1'b1;
                        rd_oor_d     = ~in_range;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Out-of-range reads show zero; between reads the last result is held.
    always_comb begin
        read_data = hold_q;
        if (read_valid_q) begin
            read_data = rd_oor_q ? '0 : arr_rdata;
        end
        hold_d = read_data;
    end

    // Controller state with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            clear_cnt_q  <= '0;
            init_done_q  <= 1'b0;
            read_valid_q <= 1'b0;
            rd_oor_q     <= 1'b0;
            addr_error_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            clear_cnt_q  <= clear_cnt_d;
            init_done_q  <= init_done_d;
            read_valid_q <= read_valid_d;
            rd_oor_q     <= rd_oor_d;
            addr_error_q <= addr_error_d;
            hold_q       <= hold_d;
        end
    end

    assign read_valid = read_valid_q;
    assign addr_error = addr_error_q;
    assign init_done  = init_done_q;

    data_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clock   (clock),
        .wr_en   (arr_wr_en),
        .rd_en   (arr_rd_en),
        .addr    (arr_addr),
        .wr_data (arr_wdata),
        .wr_mask (arr_mask),
        .rd_data (arr_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
// ============================================================================
// Module      : tb_data_ram_ctrl
// Description : Scoreboard bench for data_ram_ctrl with directed vectors
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_ram_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [9:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [3:0]  byte_enable = '0;
    logic [31:0] read_data;
    logic        read_valid;
    logic        addr_error;
    logic        init_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          rv;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t exp_q[$];

    always #5 clock = ~clock;

    data_ram_ctrl #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .DEPTH      (301)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .address     (address),
        .write_data  (write_data),
        .byte_enable (byte_enable),
        .read_data   (read_data),
        .read_valid  (read_valid),
        .addr_error  (addr_error),
        .init_done   (init_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every read_valid/addr_error strobe consumes one expectation.
    always @(negedge clock) begin
        if (!reset && (read_valid || addr_error)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: rv=%0b err=%0b data=0x%08h expected no strobe",
                         read_valid, addr_error, read_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_read_valid", {31'd0, read_valid}, {31'd0, e.rv});
                chk("sb_addr_error", {31'd0, addr_error}, {31'd0, e.err});
                if (e.rv) chk("sb_read_data", read_data, e.data);
            end
        end
    end

    task automatic issue_wr(input logic [9:0] a, input logic [31:0] d,
                            input logic [3:0] be, input bit exp_err);
        exp_t e;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; address = a;
        write_data = d; byte_enable = be;
        if (exp_err) begin
            e.rv = 1'b0; e.data = '0; e.err = 1'b1;
            exp_q.push_back(e);
        end
        @(posedge clock);
    endtask

    task automatic issue_rd(input logic [9:0] a, input logic [31:0] exp_d, input bit exp_err);
        exp_t e;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; address = a;
        write_data = '0; byte_enable = '0;
        e.rv = 1'b1; e.data = exp_d; e.err = exp_err;
        exp_q.push_back(e);
        @(posedge clock);
    endtask

    task automatic idle(input int n);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Counts clock edges until req_ready rises; drops req_valid once it does.
    task automatic measure_init(input string name);
        int  cyc;
        bit  early_done;
        cyc = 0;
        early_done = 1'b0;
        while (req_ready !== 1'b1 && cyc < 1000) begin
            if (init_done !== 1'b0) early_done = 1'b1;
            @(posedge clock);
            #1;
            cyc++;
        end
        req_valid = 1'b0;
        chk({name, "_cycles"}, cyc, 32'd301);
        chk({name, "_done_low_during_init"}, {31'd0, early_done}, 32'd0);
        chk({name, "_init_done"}, {31'd0, init_done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_read_valid", {31'd0, read_valid}, 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_addr_error", {31'd0, addr_error}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        reset = 1'b0;

        // Requests during INIT are ignored; INIT aborted at cycle 100
        req_valid = 1'b1; req_write = 1'b0; address = 10'd0;
        repeat (100) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        measure_init("init");
        idle(1);

        // Cleared contents
        issue_rd(10'd0,   32'h0000_0000, 1'b0);
        issue_rd(10'd150, 32'h0000_0000, 1'b0);
        issue_rd(10'd300, 32'h0000_0000, 1'b0);
        idle(2);

        // Byte-lane writes, including an all-zero mask no-op
        issue_wr(10'd5, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        issue_wr(10'd5, 32'h1122_3344, 4'b0101, 1'b0);
        issue_rd(10'd5, 32'hDE22_BE44, 1'b0);
        issue_wr(10'd5, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        issue_rd(10'd5, 32'hDE22_BE44, 1'b0);
        issue_wr(10'd6, 32'h0BAD_F00D, 4'b1000, 1'b0);
        issue_rd(10'd6, 32'h0B00_0000, 1'b0);

        // Read-after-write back to back, then data held after the pulse
        issue_wr(10'd7, 32'hA5A5_A5A5, 4'b1111, 1'b0);
        issue_rd(10'd7, 32'hA5A5_A5A5, 1'b0);
        idle(2);
        chk("hold_read_valid_low", {31'd0, read_valid}, 32'd0);
        chk("hold_read_data", read_data, 32'hA5A5_A5A5);

        // Out-of-range accesses
        issue_wr(10'd301,  32'hFFFF_FFFF, 4'b1111, 1'b1);
        issue_rd(10'd301,  32'h0000_0000, 1'b1);
        issue_rd(10'd1023, 32'h0000_0000, 1'b1);
        issue_rd(10'd300,  32'h0000_0000, 1'b0);
        issue_rd(10'd45,   32'h0000_0000, 1'b0);
        issue_rd(10'd7,    32'hA5A5_A5A5, 1'b0);
        idle(3);
        chk("sb_drained", exp_q.size(), 32'd0);

        // Reset while a read result is being presented
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; address = 10'd5;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        chk("inflight_read_valid", {31'd0, read_valid}, 32'd1);
        chk("inflight_read_data", read_data, 32'hDE22_BE44);
        reset = 1'b1;
        #1;
        chk("async_read_valid", {31'd0, read_valid}, 32'd0);
        chk("async_read_data", read_data, 32'd0);
        chk("async_init_done", {31'd0, init_done}, 32'd0);
        chk("async_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        measure_init("reinit");
        idle(1);
        issue_rd(10'd5, 32'h0000_0000, 1'b0);
        idle(3);
        chk("sb_final_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
